// File: rtl/design_switch_sequencer.sv
// Design switch sequencer: debounces a design request, tears down the
// current design, holds the new one in reset, then routes its GPIOs.
module design_switch_sequencer #(
  parameter int N_DESIGNS     = 12,
  parameter int GPIO_W        = 34,
  parameter int SEL_W         = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int RST_HOLD      = 4
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic [SEL_W-1:0]            design_select,
  input  logic [N_DESIGNS*GPIO_W-1:0] designs_gpio_out,
  input  logic [N_DESIGNS*GPIO_W-1:0] designs_gpio_oeb,
  output logic [GPIO_W-1:0]           gpio_out,
  output logic [GPIO_W-1:0]           gpio_oeb,
  output logic [N_DESIGNS-1:0]        designs_ncs,
  output logic [N_DESIGNS-1:0]        designs_n_rst,
  output logic [SEL_W-1:0]            active_design,
  output logic                        busy
);

  // The shared counter times both the debounce window and the reset hold.
  localparam int CNT_MAX = (STABLE_CYCLES > RST_HOLD) ? STABLE_CYCLES : RST_HOLD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    TEARDOWN,
    RESET_HOLD,
    ACTIVE
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [SEL_W-1:0]   candidate;
  logic [SEL_W-1:0]   candidate_nx;
  logic [SEL_W-1:0]   active_nx;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nx;

  // A selection names a real design only when it lies in 1..N_DESIGNS.
  function automatic logic sel_valid(input logic [SEL_W-1:0] s);
    return (s != '0) && (int'(s) <= N_DESIGNS);
  endfunction

  // One-hot vector with the bit of design a set; all zero for a == 0.
  function automatic logic [N_DESIGNS-1:0] design_bit(input logic [SEL_W-1:0] a);
    logic [N_DESIGNS-1:0] v;
    v = '0;
    for (int k = 1; k <= N_DESIGNS; k++) begin
      if (int'(a) == k) v[k-1] = 1'b1;
    end
    return v;
  endfunction

  // Next-state logic for the switch sequence.
  always_comb begin
    state_nx     = state;
    candidate_nx = candidate;
    active_nx    = active_design;
    cnt_nx       = cnt;
    case (state)
      IDLE, ACTIVE: begin
        if (design_select != active_design) begin
          state_nx     = DEBOUNCE;
          candidate_nx = design_select;
          cnt_nx       = '0;
        end
      end
      DEBOUNCE: begin
        if (design_select != candidate) begin
          candidate_nx = design_select;
          cnt_nx       = '0;
        end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          if (candidate == active_design) begin
            state_nx = (active_design == '0) ? IDLE : ACTIVE;
          end else begin
            state_nx = TEARDOWN;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      TEARDOWN: begin
        if (sel_valid(candidate)) begin
          state_nx  = RESET_HOLD;
          active_nx = candidate;
          cnt_nx    = '0;
        end else begin
          state_nx  = IDLE;
          active_nx = '0;
        end
      end
      RESET_HOLD: begin
        if (cnt == CNT_W'(RST_HOLD - 1)) begin
          state_nx = ACTIVE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State registers plus chip-select/reset/busy outputs registered from the next state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      candidate     <= '0;
      active_design <= '0;
      cnt           <= '0;
      designs_ncs   <= '1;
      designs_n_rst <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      candidate     <= candidate_nx;
      active_design <= active_nx;
      cnt           <= cnt_nx;
      busy          <= (state_nx != IDLE) && (state_nx != ACTIVE);
      case (state_nx)
        RESET_HOLD: begin
          designs_ncs   <= ~design_bit(active_nx);
          designs_n_rst <= '0;
        end
        ACTIVE, DEBOUNCE: begin
          designs_ncs   <= ~design_bit(active_nx);
          designs_n_rst <= design_bit(active_nx);
        end
        default: begin
          designs_ncs   <= '1;
          designs_n_rst <= '0;
        end
      endcase
    end
  end

  // GPIO routing from the active design's slice; parked outputs otherwise.
  always_comb begin
    gpio_out = '0;
    gpio_oeb = '1;
    if ((state == ACTIVE || state == DEBOUNCE) && active_design != '0) begin
      for (int k = 1; k <= N_DESIGNS; k++) begin
        if (int'(active_design) == k) begin
          gpio_out = designs_gpio_out[(k-1)*GPIO_W +: GPIO_W];
          gpio_oeb = designs_gpio_oeb[(k-1)*GPIO_W +: GPIO_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_design_switch_sequencer.sv
// Testbench for design_switch_sequencer: table vectors, a reset-abort
// sequence and randomized selects checked against a behavioural model.
module tb_design_switch_sequencer;

  localparam int N      = 12;
  localparam int GW     = 34;
  localparam int SW     = 4;
  localparam int STABLE = 2;
  localparam int RH     = 4;
  localparam int BUS_W  = N * GW;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [SW-1:0]     design_select;
  logic [BUS_W-1:0]  designs_gpio_out;
  logic [BUS_W-1:0]  designs_gpio_oeb;
  logic [GW-1:0]     gpio_out;
  logic [GW-1:0]     gpio_oeb;
  logic [N-1:0]      designs_ncs;
  logic [N-1:0]      designs_n_rst;
  logic [SW-1:0]     active_design;
  logic              busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model: who is active, what request is being watched and
  // for how long, and how many cycles remain of a teardown + reset hold.
  int m_active;
  int m_req;
  int m_age;
  int m_watch;
  int m_sw;
  int m_tgt;

  typedef struct {
    logic [SW-1:0] sel;
    logic [N-1:0]  ncs;
    logic [N-1:0]  nrst;
    logic [SW-1:0] act;
    logic          bsy;
    int            gd;
  } vec_t;

  vec_t vecs[$];

  design_switch_sequencer #(
    .N_DESIGNS(N), .GPIO_W(GW), .SEL_W(SW), .STABLE_CYCLES(STABLE), .RST_HOLD(RH)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .design_select(design_select),
    .designs_gpio_out(designs_gpio_out),
    .designs_gpio_oeb(designs_gpio_oeb),
    .gpio_out(gpio_out),
    .gpio_oeb(gpio_oeb),
    .designs_ncs(designs_ncs),
    .designs_n_rst(designs_n_rst),
    .active_design(active_design),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Record one comparison and report it when it disagrees.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [GW-1:0] getSlice(input logic [BUS_W-1:0] bus, input int k);
    logic [BUS_W-1:0] t;
    t = bus >> ((k - 1) * GW);
    return t[GW-1:0];
  endfunction

  function automatic logic [N-1:0] designBit(input int a);
    logic [N-1:0] v;
    v = '0;
    if (a >= 1 && a <= N) v[a-1] = 1'b1;
    return v;
  endfunction

  task automatic randomizeBus();
    logic [BUS_W+31:0] t0;
    logic [BUS_W+31:0] t1;
    for (int i = 0; i <= BUS_W / 32; i++) begin
      t0[i*32 +: 32] = $urandom();
      t1[i*32 +: 32] = $urandom();
    end
    designs_gpio_out = t0[BUS_W-1:0];
    designs_gpio_oeb = t1[BUS_W-1:0];
  endtask

  task automatic modelReset();
    m_active = 0;
    m_req    = 0;
    m_age    = 0;
    m_watch  = 0;
    m_sw     = 0;
    m_tgt    = 0;
  endtask

  // Advance the model by one clock edge given the select seen at that edge.
  task automatic modelStep(input int s);
    if (m_sw > 0) begin
      m_sw--;
      if (m_sw == RH) begin
        if (m_tgt >= 1 && m_tgt <= N) begin
          m_active = m_tgt;
        end else begin
          m_active = 0;
          m_sw     = 0;
        end
      end
    end else if (m_watch != 0) begin
      if (s != m_req) begin
        m_req = s;
        m_age = 1;
      end else if (m_age == STABLE) begin
        m_watch = 0;
        if (m_req != m_active) begin
          m_sw  = RH + 1;
          m_tgt = m_req;
        end
      end else begin
        m_age++;
      end
    end else if (s != m_active) begin
      m_watch = 1;
      m_req   = s;
      m_age   = 1;
    end
  endtask

  task automatic checkModel(input string tag);
    logic [N-1:0]  e_ncs;
    logic [N-1:0]  e_nrst;
    logic [GW-1:0] e_out;
    logic [GW-1:0] e_oeb;
    logic          e_busy;
    e_ncs  = (m_sw == RH + 1) ? '1 : ~designBit(m_active);
    e_nrst = (m_sw > 0) ? '0 : designBit(m_active);
    e_busy = (m_watch != 0) || (m_sw > 0);
    e_out  = '0;
    e_oeb  = '1;
    if (m_sw == 0 && m_active != 0) begin
      e_out = getSlice(designs_gpio_out, m_active);
      e_oeb = getSlice(designs_gpio_oeb, m_active);
    end
    checkOutput({tag, ".ncs"}, 64'(designs_ncs), 64'(e_ncs));
    checkOutput({tag, ".n_rst"}, 64'(designs_n_rst), 64'(e_nrst));
    checkOutput({tag, ".busy"}, 64'(busy), 64'(e_busy));
    checkOutput({tag, ".active"}, 64'(active_design), 64'(m_active));
    checkOutput({tag, ".gpio_out"}, 64'(gpio_out), 64'(e_out));
    checkOutput({tag, ".gpio_oeb"}, 64'(gpio_oeb), 64'(e_oeb));
    checkOutput({tag, ".ncs_onehot"}, 64'($countones(~designs_ncs) <= 1), 64'(1));
    checkOutput({tag, ".nrst_onehot"}, 64'($countones(designs_n_rst) <= 1), 64'(1));
  endtask

  // Drive a select, clock one edge, advance the model, settle past the edge.
  task automatic applyStimulus(input logic [SW-1:0] sel);
    design_select = sel;
    randomizeBus();
    @(posedge clk);
    modelStep(int'(sel));
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".ncs"}, 64'(designs_ncs), 64'(12'hFFF));
    checkOutput({tag, ".n_rst"}, 64'(designs_n_rst), 64'(12'h000));
    checkOutput({tag, ".active"}, 64'(active_design), 64'(0));
    checkOutput({tag, ".busy"}, 64'(busy), 64'(0));
    checkOutput({tag, ".gpio_out"}, 64'(gpio_out), 64'(0));
    checkOutput({tag, ".gpio_oeb"}, 64'(gpio_oeb), {30'd0, {GW{1'b1}}});
  endtask

  // Assert reset asynchronously, check the parked outputs, release at a falling edge.
  task automatic resetDut(input string tag);
    n_rst = 1'b0;
    #2;
    modelReset();
    checkResetValues(tag);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  function automatic void addVec(input logic [SW-1:0] sel, input logic [N-1:0] ncs,
                                 input logic [N-1:0] nrst, input logic [SW-1:0] act,
                                 input logic bsy, input int gd);
    vec_t v;
    v.sel  = sel;
    v.ncs  = ncs;
    v.nrst = nrst;
    v.act  = act;
    v.bsy  = bsy;
    v.gd   = gd;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [SW-1:0] sel;
    logic [GW-1:0] e_out;
    logic [GW-1:0] e_oeb;
    n_rst         = 1'b1;
    design_select = '0;
    randomizeBus();
    #3;
    resetDut("reset");

    // Switch 0 -> 3, glitch to 5, then request invalid design 13.
    addVec(4'd3, 12'hFFF, 12'h000, 4'd0, 1'b1, 0);
    addVec(4'd3, 12'hFFF, 12'h000, 4'd0, 1'b1, 0);
    addVec(4'd3, 12'hFFF, 12'h000, 4'd0, 1'b1, 0);
    for (int i = 0; i < RH; i++) addVec(4'd3, 12'hFFB, 12'h000, 4'd3, 1'b1, 0);
    addVec(4'd3, 12'hFFB, 12'h004, 4'd3, 1'b0, 3);
    addVec(4'd5, 12'hFFB, 12'h004, 4'd3, 1'b1, 3);
    addVec(4'd3, 12'hFFB, 12'h004, 4'd3, 1'b1, 3);
    addVec(4'd3, 12'hFFB, 12'h004, 4'd3, 1'b1, 3);
    addVec(4'd3, 12'hFFB, 12'h004, 4'd3, 1'b0, 3);
    addVec(4'd13, 12'hFFB, 12'h004, 4'd3, 1'b1, 3);
    addVec(4'd13, 12'hFFB, 12'h004, 4'd3, 1'b1, 3);
    addVec(4'd13, 12'hFFF, 12'h000, 4'd3, 1'b1, 0);
    addVec(4'd13, 12'hFFF, 12'h000, 4'd0, 1'b0, 0);
    addVec(4'd0, 12'hFFF, 12'h000, 4'd0, 1'b0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sel);
      e_out = '0;
      e_oeb = '1;
      if (vecs[i].gd != 0) begin
        e_out = getSlice(designs_gpio_out, vecs[i].gd);
        e_oeb = getSlice(designs_gpio_oeb, vecs[i].gd);
      end
      checkOutput($sformatf("vec%0d.ncs", i), 64'(designs_ncs), 64'(vecs[i].ncs));
      checkOutput($sformatf("vec%0d.n_rst", i), 64'(designs_n_rst), 64'(vecs[i].nrst));
      checkOutput($sformatf("vec%0d.active", i), 64'(active_design), 64'(vecs[i].act));
      checkOutput($sformatf("vec%0d.busy", i), 64'(busy), 64'(vecs[i].bsy));
      checkOutput($sformatf("vec%0d.gpio_out", i), 64'(gpio_out), 64'(e_out));
      checkOutput($sformatf("vec%0d.gpio_oeb", i), 64'(gpio_oeb), 64'(e_oeb));
    end

    // Bring design 3 up, start a switch to 7, abort it with reset during the hold.
    for (int i = 0; i < 8; i++) applyStimulus(4'd3);
    checkOutput("abort.pre_active", 64'(active_design), 64'(3));
    for (int i = 0; i < 4; i++) applyStimulus(4'd7);
    checkOutput("abort.hold_ncs", 64'(designs_ncs), 64'(12'hFBF));
    checkOutput("abort.hold_busy", 64'(busy), 64'(1));
    resetDut("abort.reset");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'd7);
      if (i == 6) begin
        checkOutput("abort.edge6_busy", 64'(busy), 64'(1));
        checkOutput("abort.edge6_n_rst", 64'(designs_n_rst), 64'(12'h000));
        checkOutput("abort.edge6_ncs", 64'(designs_ncs), 64'(12'hFBF));
      end
    end
    checkOutput("abort.edge7_active", 64'(active_design), 64'(7));
    checkOutput("abort.edge7_n_rst", 64'(designs_n_rst), 64'(12'h040));
    checkOutput("abort.edge7_ncs", 64'(designs_ncs), 64'(12'hFBF));
    checkOutput("abort.edge7_busy", 64'(busy), 64'(0));
    checkOutput("abort.edge7_gpio", 64'(gpio_out), 64'(getSlice(designs_gpio_out, 7)));

    // Randomized select toggling against the behavioural model.
    resetDut("rand.reset");
    sel = '0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(3) == 0) sel = SW'($urandom_range(15));
      applyStimulus(sel);
      checkModel($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/design_switch_sequencer.md
DESIGN_SWITCH_SEQUENCER -- requirements
Module: design_switch_sequencer

Interface
REQ-001 Parameter: N_DESIGNS, 12, number of selectable designs, numbered 1..N_DESIGNS.
REQ-002 Parameter: GPIO_W, 34, GPIO bus width per design.
REQ-003 Parameter: SEL_W, 4, width of design_select; SHALL satisfy 2**SEL_W > N_DESIGNS.
REQ-004 Parameter: STABLE_CYCLES, 2, consecutive cycles design_select must hold before a switch; minimum 1.
REQ-005 Parameter: RST_HOLD, 4, cycles the new design is held in reset after selection; minimum 1.
REQ-006 Port: clk  input  1  single clock; all state on rising edge.
REQ-007 Port: n_rst  input  1  reset, asynchronous, active-low.
REQ-008 Port: design_select  input  SEL_W  requested design; 0 or >N_DESIGNS means none.
REQ-009 Port: designs_gpio_out  input  N_DESIGNS*GPIO_W  design k drives slice [k*GPIO_W-1 : (k-1)*GPIO_W].
REQ-010 Port: designs_gpio_oeb  input  N_DESIGNS*GPIO_W  same slicing; active-low output enables.
REQ-011 Port: gpio_out  output  GPIO_W  routed output of the active design.
REQ-012 Port: gpio_oeb  output  GPIO_W  routed enables of the active design.
REQ-013 Port: designs_ncs  output  N_DESIGNS  active-low chip selects; bit k-1 belongs to design k.
REQ-014 Port: designs_n_rst  output  N_DESIGNS  active-low per-design resets; bit k-1 belongs to design k.
REQ-015 Port: active_design  output  SEL_W  registered index of the current design; 0 = none.
REQ-016 Port: busy  output  1  high in every state except IDLE and ACTIVE.

Function
REQ-017 FSM states SHALL be IDLE, DEBOUNCE, TEARDOWN, RESET_HOLD, ACTIVE, with registers candidate (SEL_W), cnt, and active_design.
REQ-018 IDLE and ACTIVE: if design_select != active_design -> DEBOUNCE, candidate<=design_select, cnt<=0.
REQ-019 DEBOUNCE, design_select != candidate: candidate<=design_select, cnt<=0, remain in DEBOUNCE.
REQ-020 DEBOUNCE, design_select == candidate and cnt == STABLE_CYCLES-1: if candidate == active_design -> back to ACTIVE (or IDLE when active_design==0) with no reset/ncs disturbance; else -> TEARDOWN.
REQ-021 DEBOUNCE, otherwise: cnt<=cnt+1.
REQ-022 TEARDOWN lasts exactly 1 cycle: all designs_ncs=1, all designs_n_rst=0; next: candidate invalid -> IDLE with active_design<=0; valid -> RESET_HOLD with active_design<=candidate, cnt<=0.
REQ-023 RESET_HOLD lasts exactly RST_HOLD cycles: designs_ncs[active_design-1]=0, all designs_n_rst=0; design_select changes are ignored; then -> ACTIVE.
REQ-024 ACTIVE: designs_ncs[active_design-1]=0 and designs_n_rst[active_design-1]=1; all other bits ncs=1, n_rst=0.
REQ-025 In DEBOUNCE the previously active design keeps its ncs/n_rst values and output routing unchanged.
REQ-026 gpio_out/gpio_oeb SHALL be combinational from the active design slice when in ACTIVE or DEBOUNCE with active_design != 0; otherwise gpio_out all 0 and gpio_oeb all 1.
REQ-027 At most one designs_ncs bit SHALL be 0 in any cycle; at most one designs_n_rst bit SHALL be 1 in any cycle.
REQ-028 designs_ncs, designs_n_rst, and busy SHALL be decoded from registered state only (glitch-free).

Reset
REQ-029 n_rst low SHALL asynchronously force: state IDLE, active_design=0, candidate=0, cnt=0, designs_ncs all 1, designs_n_rst all 0, busy=0, gpio_out all 0, gpio_oeb all 1.
REQ-030 Reset asserted mid-switch (any state) SHALL abort the sequence; after release, the block restarts from IDLE and re-evaluates design_select.

Verification (defaults, edge 0 = first edge with the new select)
REQ-031 Reset, select=0 -> ncs=0xFFF, n_rst=0x000, oeb all 1, active_design=0, busy=0.
REQ-032 select 0->3 held -> DEBOUNCE at edge 0, TEARDOWN at edge 2, RESET_HOLD edges 3-6 with ncs=0xFFB and n_rst=0; ACTIVE at edge 7 with n_rst=0x004, active_design=3, and gpio routed from slice 3.
REQ-033 Active 3, select pulses to 5 for 1 cycle then returns to 3 -> no TEARDOWN; ncs stays 0xFFB and n_rst stays 0x004 throughout; busy high 2-3 cycles.
REQ-034 Active 3, select->13 held -> TEARDOWN, then IDLE with active_design=0, ncs=0xFFF, oeb all 1.
REQ-035 Active 3, select->7 with n_rst pulsed low during RESET_HOLD -> immediate IDLE reset values; after release, a full 7-edge sequence to design 7.
REQ-036 Random select toggling for 10k cycles -> assert REQ-027 one-hot/zero-hot every cycle.
